// File: rtl/cic_int_chain.sv
`default_nettype none
// ============================================================================
//  Module      : cic_int_chain
//  Description : Cascade of N integrator stages for the CIC decimator front
//                end. The input is sign-extended to W = WIN+WG bits. Every
//                stage is a W-bit accumulator with wrap-around arithmetic,
//                and all stages advance together on each accepted sample.
//                The last stage is presented as the top WOUT bits.
//                Optional macro CIC_INT_CHAIN_ROUND_EN rounds the output
//                (add half an output LSB before dropping bits) instead of
//                truncating it.
//  Revision    : 1.0 - initial release
// ============================================================================
module cic_int_chain #(
    parameter int WIN  = 16,   // input sample width, signed
    parameter int WG   = 22,   // bit growth
    parameter int N    = 3,    // number of integrator stages, 1..8
    parameter int WOUT = 38    // output width, 1..WIN+WG
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            val_in,
    input  logic [WIN-1:0]  data_in,
    output logic            val_out,
    output logic [WOUT-1:0] data_out
);

    // Full accumulator width.
    localparam int c_W = WIN + WG;

    logic [c_W-1:0]  w_din_ext;
    logic [c_W-1:0]  w_addend   [N];
    logic [c_W-1:0]  w_acc_next [N];
    logic [c_W-1:0]  r_acc      [N];
    logic [c_W-1:0]  w_out_full;
    logic [WOUT-1:0] w_out_sel;

    // Two's complement sign extension of the incoming sample to full width.
    assign w_din_ext = {{WG{data_in[WIN-1]}}, data_in};

    // Each stage adds either the new sample (first stage) or the pre-edge
    // value of the previous stage. Using pre-edge values is what makes all
    // stages update simultaneously and gives the N-1 sample pipeline delay
    // through the chain.
    for (genvar k = 0; k < N; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign w_addend[k] = w_din_ext;
        end else begin : g_tail
            assign w_addend[k] = r_acc[k-1];
        end

        // Modulo 2^W sum: overflow wraps, which the comb section undoes.
        assign w_acc_next[k] = r_acc[k] + w_addend[k];
    end

    // Output select operates on the value the last stage takes at this edge,
    // so data_out appears together with the update (one clock latency).
`ifdef CIC_INT_CHAIN_ROUND_EN
    if (WOUT < c_W) begin : g_round
        // Half of one output LSB, expressed at full width.
        localparam logic [c_W-1:0] c_HALF =
            {{(c_W-1){1'b0}}, 1'b1} << (c_W - WOUT - 1);

        // Rounding add also wraps, like the accumulators themselves.
        assign w_out_full = w_acc_next[N-1] + c_HALF;
    end else begin : g_full
        assign w_out_full = w_acc_next[N-1];
    end
`else
    assign w_out_full = w_acc_next[N-1];
`endif

    // Keep the top WOUT bits; the shift keeps the discarded LSBs referenced.
    assign w_out_sel = WOUT'(w_out_full >> (c_W - WOUT));

    // Integrator state: async reset, sync clear wins over a valid sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                r_acc[k] <= '0;
            end
        end else if (clr) begin
            for (int k = 0; k < N; k++) begin
                r_acc[k] <= '0;
            end
        end else if (val_in) begin
            for (int k = 0; k < N; k++) begin
                r_acc[k] <= w_acc_next[k];
            end
        end
    end

    // Output register: one-cycle valid pulse per accepted sample, data held
    // between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_out  <= 1'b0;
            data_out <= '0;
        end else if (clr) begin
            val_out  <= 1'b0;
            data_out <= '0;
        end else if (val_in) begin
            val_out  <= 1'b1;
            data_out <= w_out_sel;
        end else begin
            val_out  <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cic_int_chain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cic_int_chain
//  Description : Self-checking bench for cic_int_chain. Five instances cover
//                the default chain, a narrowed output, N=2, a small wrapping
//                configuration and a truncate/round configuration. Table
//                vectors, hand-written reset sequences and a randomized run
//                against a closed-form (binomial-weighted sum) model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cic_int_chain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Group 1: defaults (A) and WOUT=20 (B) share stimulus
    logic        clr1, val1;
    logic [15:0] din1;
    logic        vo_a, vo_b;
    logic [37:0] do_a;
    logic [19:0] do_b;
    // Group 2: N=2
    logic        clr2, val2;
    logic [15:0] din2;
    logic        vo_c;
    logic [37:0] do_c;
    // Group 3: WIN=4, WG=2, N=1, WOUT=6
    logic        clr3, val3;
    logic [3:0]  din3;
    logic        vo_d;
    logic [5:0]  do_d;
    // Group 4: WIN=16, WG=2, N=1, WOUT=16
    logic        clr4, val4;
    logic [15:0] din4;
    logic        vo_e;
    logic [15:0] do_e;

    cic_int_chain #(.WIN(16), .WG(22), .N(3), .WOUT(38)) dut_a (
        .clk(clk), .rst(rst), .clr(clr1), .val_in(val1), .data_in(din1),
        .val_out(vo_a), .data_out(do_a));
    cic_int_chain #(.WIN(16), .WG(22), .N(3), .WOUT(20)) dut_b (
        .clk(clk), .rst(rst), .clr(clr1), .val_in(val1), .data_in(din1),
        .val_out(vo_b), .data_out(do_b));
    cic_int_chain #(.WIN(16), .WG(22), .N(2), .WOUT(38)) dut_c (
        .clk(clk), .rst(rst), .clr(clr2), .val_in(val2), .data_in(din2),
        .val_out(vo_c), .data_out(do_c));
    cic_int_chain #(.WIN(4), .WG(2), .N(1), .WOUT(6)) dut_d (
        .clk(clk), .rst(rst), .clr(clr3), .val_in(val3), .data_in(din3),
        .val_out(vo_d), .data_out(do_d));
    cic_int_chain #(.WIN(16), .WG(2), .N(1), .WOUT(16)) dut_e (
        .clk(clk), .rst(rst), .clr(clr4), .val_in(val4), .data_in(din4),
        .val_out(vo_e), .data_out(do_e));

`ifdef CIC_INT_CHAIN_ROUND_EN
    localparam bit c_RND = 1'b1;
`else
    localparam bit c_RND = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int     grp;
        logic   clr;
        logic   val;
        longint din;
        logic   exp_val;
        longint exp_data;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int g, logic c, logic v, longint d, logic ev, longint ed);
        vec_t r;
        r.grp = g; r.clr = c; r.val = v; r.din = d; r.exp_val = ev; r.exp_data = ed;
        return r;
    endfunction

    task automatic check(string name, longint act, longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        clr1 = 0; val1 = 0; clr2 = 0; val2 = 0;
        clr3 = 0; val3 = 0; clr4 = 0; val4 = 0;
    endtask

    task automatic apply(vec_t v, string tag);
        longint av, ad;
        idle_all();
        case (v.grp)
            1: begin clr1 = v.clr; val1 = v.val; din1 = v.din[15:0]; end
            2: begin clr2 = v.clr; val2 = v.val; din2 = v.din[15:0]; end
            3: begin clr3 = v.clr; val3 = v.val; din3 = v.din[3:0];  end
            default: begin clr4 = v.clr; val4 = v.val; din4 = v.din[15:0]; end
        endcase
        tick();
        case (v.grp)
            1: begin av = longint'(vo_a); ad = $signed(do_a); end
            2: begin av = longint'(vo_c); ad = $signed(do_c); end
            3: begin av = longint'(vo_d); ad = $signed(do_d); end
            default: begin av = longint'(vo_e); ad = $signed(do_e); end
        endcase
        check({tag, ".val_out"}, av, longint'(v.exp_val));
        check({tag, ".data_out"}, ad, v.exp_data);
    endtask

    // Number of ways to choose k from n; zero when n < k.
    function automatic longint binom(int n, int k);
        longint c = 1;
        if (n < k) return 0;
        for (int i = 1; i <= k; i++) c = c * (n - k + i) / i;
        return c;
    endfunction

    // Output value for a W-bit accumulation, top WOUT bits, signed.
    function automatic longint sel(longint acc, int w, int wout, bit rnd);
        longint mask = (64'sd1 <<< w) - 1;
        longint v = acc & mask;
        if (rnd && wout < w) v = (v + (64'sd1 <<< (w - wout - 1))) & mask;
        v = v >> (w - wout);
        if (v[wout-1]) v = v - (64'sd1 <<< wout);
        return v;
    endfunction

    // Last stage of an N-stage chain after the samples in xs: each stage
    // adds one sample of delay, so sample j (1-based) after m samples is
    // weighted by C(m-j, N-1).
    function automatic longint chain_out(longint xs[$], int nst);
        longint s = 0;
        int m = xs.size();
        for (int j = 0; j < m; j++) s += binom(m - 1 - j, nst - 1) * xs[j];
        return s;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        longint imp_exp[6];
        longint xs[$];
        longint exp_a, exp_b;
        logic   exp_v;
        logic [15:0] r;

        rst = 1'b1;
        idle_all();
        din1 = '0; din2 = '0; din3 = '0; din4 = '0;

        // ---- reset state -------------------------------------------------
        tick(); tick();
        check("rst.val_a", longint'(vo_a), 0);
        check("rst.data_a", $signed(do_a), 0);
        check("rst.data_b", $signed(do_b), 0);
        check("rst.val_d", longint'(vo_d), 0);
        check("rst.data_e", $signed(do_e), 0);
        rst = 1'b0;

        // ---- vector table ------------------------------------------------
        // Impulse through three stages: 0,0,1,3,6,10.
        imp_exp = '{0, 0, 1, 3, 6, 10};
        for (int i = 0; i < 6; i++)
            tbl.push_back(mk(1, 0, 1, (i == 0) ? 1 : 0, 1, imp_exp[i]));
        tbl.push_back(mk(1, 1, 1, 5, 0, 0));              // clear drops sample
        // Same impulse with three idle cycles after each sample.
        for (int i = 0; i < 6; i++) begin
            tbl.push_back(mk(1, 0, 1, (i == 0) ? 1 : 0, 1, imp_exp[i]));
            for (int g = 0; g < 3; g++)
                tbl.push_back(mk(1, 0, 0, 9, 0, imp_exp[i]));
        end
        // Step into two stages: 0,1,3,6, then clear with val_in high.
        tbl.push_back(mk(2, 0, 1, 1, 1, 0));
        tbl.push_back(mk(2, 0, 1, 1, 1, 1));
        tbl.push_back(mk(2, 0, 1, 1, 1, 3));
        tbl.push_back(mk(2, 0, 1, 1, 1, 6));
        tbl.push_back(mk(2, 1, 1, 1, 0, 0));
        tbl.push_back(mk(2, 0, 1, 1, 1, 0));
        tbl.push_back(mk(2, 0, 1, 1, 1, 1));
        tbl.push_back(mk(2, 0, 0, 1, 0, 1));
        // 6-bit wrap: 35 mod 64 reads as -29.
        tbl.push_back(mk(3, 0, 1, 7, 1, 7));
        tbl.push_back(mk(3, 0, 1, 7, 1, 14));
        tbl.push_back(mk(3, 0, 1, 7, 1, 21));
        tbl.push_back(mk(3, 0, 1, 7, 1, 28));
        tbl.push_back(mk(3, 0, 1, 7, 1, -29));
        // acc = 2,3,4 with two LSBs dropped.
        tbl.push_back(mk(4, 0, 1, 2, 1, c_RND ? 1 : 0));
        tbl.push_back(mk(4, 0, 1, 1, 1, c_RND ? 1 : 0));
        tbl.push_back(mk(4, 0, 1, 1, 1, 1));

        foreach (tbl[i]) apply(tbl[i], $sformatf("tbl%0d_g%0d", i, tbl[i].grp));

        // ---- asynchronous reset mid-stream (N=2) -------------------------
        apply(mk(2, 0, 1, 1, 1, 3), "arst.pre");
        idle_all();
        #2 rst = 1'b1;
        #1;
        check("arst.val_c", longint'(vo_c), 0);
        check("arst.data_c", $signed(do_c), 0);
        check("arst.data_a", $signed(do_a), 0);
        rst = 1'b0;
        apply(mk(2, 0, 1, 1, 1, 0), "arst.s1");
        apply(mk(2, 0, 1, 1, 1, 1), "arst.s2");

        // ---- randomized run against closed-form model --------------------
        rst = 1'b1;
        #1 rst = 1'b0;
        idle_all();
        exp_a = 0; exp_b = 0;
        for (int c = 0; c < 400; c++) begin
            r    = 16'($urandom);
            clr1 = ($urandom_range(0, 39) == 0);
            val1 = ($urandom_range(0, 9) < 7);
            din1 = r;
            tick();
            if (clr1) begin
                xs.delete();
                exp_v = 0; exp_a = 0; exp_b = 0;
            end else if (val1) begin
                xs.push_back(longint'($signed(r)));
                exp_v = 1;
                exp_a = sel(chain_out(xs, 3), 38, 38, c_RND);
                exp_b = sel(chain_out(xs, 3), 38, 20, c_RND);
            end else begin
                exp_v = 0;
            end
            check($sformatf("rnd%0d.val_a", c), longint'(vo_a), longint'(exp_v));
            check($sformatf("rnd%0d.val_b", c), longint'(vo_b), longint'(exp_v));
            check($sformatf("rnd%0d.data_a", c), $signed(do_a), exp_a);
            check($sformatf("rnd%0d.data_b", c), $signed(do_b), exp_b);
        end
        idle_all();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
